// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Boots a program into instruction memory from a streaming loader, then
//   serves fetch-stage reads from that memory.
//
//   Parameters
//     Num_of_bits      : instruction word width
//     Num_of_registers : memory address width (depth 2**Num_of_registers)
//
//   Ports
//     clk, rst                        : clock, synchronous active-high reset
//     start                           : one-cycle pulse, begins a program load
//     ld_valid/ld_data/ld_last        : loader word stream
//     ld_ready                        : loader word accepted this cycle
//     fetch_req/fetch_addr            : fetch read request
//     fetch_valid/fetch_data          : fetch response, one cycle after request
//     stall                           : fetch request refused this cycle
//     mem_we/mem_addr/mem_wdata       : shared memory write/read port
//     mem_rdata                       : synchronous read data (1-cycle latency)
//     load_done                       : program resident, fetch enabled
//     word_count                      : words written by last/current load
//     overflow_err                    : load ran past the end of memory
module imem_boot_ctrl #(
  parameter int Num_of_bits      = 16,
  parameter int Num_of_registers = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ld_valid,
  input  logic [Num_of_bits-1:0]      ld_data,
  input  logic                        ld_last,
  output logic                        ld_ready,
  input  logic                        fetch_req,
  input  logic [Num_of_registers-1:0] fetch_addr,
  output logic                        fetch_valid,
  output logic [Num_of_bits-1:0]      fetch_data,
  output logic                        stall,
  output logic                        mem_we,
  output logic [Num_of_registers-1:0] mem_addr,
  output logic [Num_of_bits-1:0]      mem_wdata,
  input  logic [Num_of_bits-1:0]      mem_rdata,
  output logic                        load_done,
  output logic [Num_of_registers:0]   word_count,
  output logic                        overflow_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [Num_of_registers-1:0] PTR_MAX = '1;

  state_t                      state_q, state_d;
  logic [Num_of_registers-1:0] ptr_q, ptr_d;
  logic [Num_of_registers:0]   cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        ovf_q, ovf_d;
  logic                        fvalid_q;
  logic [Num_of_bits-1:0]      fhold_q;
  logic                        fetch_issue;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = fetch_addr;
    mem_wdata   = ld_data;
    fetch_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        mem_addr = ptr_q;
        if (ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (ld_last) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (ptr_q == PTR_MAX) begin
            // Last slot written with more words still coming: memory is full.
            state_d = ERR;
            ovf_d   = 1'b1;
          end
        end
      end
      RUN: begin
        // A reload request takes priority over a fetch in the same cycle.
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else if (fetch_req) begin
          fetch_issue = 1'b1;
        end
      end
      default: ; // ERR is sticky until reset
    endcase

    // Nothing is handshaken or written while reset is asserted.
    if (rst) begin
      ld_ready    = 1'b0;
      mem_we      = 1'b0;
      fetch_issue = 1'b0;
    end
  end

  assign stall = fetch_req && !(state_q == RUN && !start && !rst);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fvalid_q <= 1'b0;
      fhold_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      fvalid_q <= fetch_issue;
      if (fvalid_q) fhold_q <= mem_rdata;
    end
  end

  assign fetch_valid  = fvalid_q;
  // Live read data while valid, otherwise the last word returned.
  assign fetch_data   = fvalid_q ? mem_rdata : fhold_q;
  assign load_done    = done_q;
  assign word_count   = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          overflow_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.Num_of_bits(DW), .Num_of_registers(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .stall(stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_done(load_done), .word_count(word_count), .overflow_err(overflow_err)
  );

  // Synchronous-read memory model plus a log of every write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wlog_addr [0:63];
  logic [DW-1:0] wlog_data [0:63];
  int            wr_n = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]   <= mem_wdata;
      wlog_addr[wr_n] <= mem_addr;
      wlog_data[wr_n] <= mem_wdata;
      wr_n            <= wr_n + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one loader word; mem_we/mem_addr checked before the edge.
  task automatic push_word(input logic [DW-1:0] d, input logic last, input int exp_addr, input string tag);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    check_eq({tag, "_we"}, 32'(mem_we), 32'd1);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_req = 1'b1; fetch_addr = '0;

    // ---- reset state
    tick(); tick();
    check_eq("rst_stall", 32'(stall), 32'd1);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_overflow", 32'(overflow_err), 32'd0);
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_fetch_data", 32'(fetch_data), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_stall", 32'(stall), 32'd1);
    fetch_req = 1'b0;

    // ---- basic load
    start = 1'b1; tick(); start = 1'b0;
    check_eq("load_ld_ready", 32'(ld_ready), 32'd1);
    base = wr_n;
    push_word(16'h1111, 1'b0, 0, "basic0");
    push_word(16'h2222, 1'b0, 1, "basic1");
    check_eq("basic_not_done", 32'(load_done), 32'd0);
    push_word(16'h3333, 1'b1, 2, "basic2");
    check_eq("basic_load_done", 32'(load_done), 32'd1);
    check_eq("basic_word_count", 32'(word_count), 32'd3);
    check_eq("basic_ld_ready_off", 32'(ld_ready), 32'd0);
    check_eq("basic_writes", 32'(wr_n - base), 32'd3);
    check_eq("basic_wdata1", 32'(wlog_data[base+1]), 32'h2222);

    // ---- back-to-back fetches: 2, 0, 1
    fetch_req = 1'b1; fetch_addr = 3'd2; #1;
    check_eq("fetch_stall", 32'(stall), 32'd0);
    check_eq("fetch_mem_we", 32'(mem_we), 32'd0);
    check_eq("fetch_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    check_eq("fetch0_valid", 32'(fetch_valid), 32'd1);
    check_eq("fetch0_data", 32'(fetch_data), 32'h3333);
    fetch_addr = 3'd0; tick();
    check_eq("fetch1_valid", 32'(fetch_valid), 32'd1);
    check_eq("fetch1_data", 32'(fetch_data), 32'h1111);
    fetch_addr = 3'd1; tick();
    check_eq("fetch2_valid", 32'(fetch_valid), 32'd1);
    check_eq("fetch2_data", 32'(fetch_data), 32'h2222);
    fetch_req = 1'b0; fetch_addr = 3'd0; tick();
    check_eq("fetch_idle_valid", 32'(fetch_valid), 32'd0);
    check_eq("fetch_hold_data", 32'(fetch_data), 32'h2222);

    // ---- start + fetch_req in RUN: start wins
    start = 1'b1; fetch_req = 1'b1; #1;
    check_eq("cont_stall", 32'(stall), 32'd1);
    check_eq("cont_mem_we", 32'(mem_we), 32'd0);
    tick(); start = 1'b0;
    check_eq("cont_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("cont_in_load", 32'(ld_ready), 32'd1);
    check_eq("cont_word_count", 32'(word_count), 32'd0);
    check_eq("cont_load_done", 32'(load_done), 32'd0);
    // fetch during LOAD is refused
    #1;
    check_eq("load_stall", 32'(stall), 32'd1);
    tick();
    check_eq("load_fetch_valid", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;

    // ---- gapped load: valid 1,0,1,1, last on third accepted word
    base = wr_n;
    push_word(16'hAAAA, 1'b0, 0, "gap0");
    #1;
    check_eq("gap_no_we", 32'(mem_we), 32'd0);
    tick();
    check_eq("gap_hold_count", 32'(word_count), 32'd1);
    push_word(16'hBBBB, 1'b0, 1, "gap1");
    push_word(16'hCCCC, 1'b1, 2, "gap2");
    check_eq("gap_writes", 32'(wr_n - base), 32'd3);
    check_eq("gap_word_count", 32'(word_count), 32'd3);
    check_eq("gap_load_done", 32'(load_done), 32'd1);
    fetch_req = 1'b1; fetch_addr = 3'd1; tick();
    fetch_req = 1'b0;
    check_eq("gap_fetch_data", 32'(fetch_data), 32'hBBBB);

    // ---- overflow: 8 words, no ld_last
    start = 1'b1; tick(); start = 1'b0;
    base = wr_n;
    for (int i = 0; i < 8; i++) begin
      push_word(16'(16'h0100 + i), 1'b0, i, $sformatf("ovf%0d", i));
    end
    check_eq("ovf_writes", 32'(wr_n - base), 32'd8);
    check_eq("ovf_last_addr", 32'(wlog_addr[base+7]), 32'd7);
    check_eq("ovf_err", 32'(overflow_err), 32'd1);
    check_eq("ovf_word_count", 32'(word_count), 32'd8);
    check_eq("ovf_ld_ready", 32'(ld_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1; fetch_req = 1'b1; #1;
    check_eq("err_ignore_start", 32'(ld_ready), 32'd0);
    check_eq("err_no_we", 32'(mem_we), 32'd0);
    check_eq("err_stall", 32'(stall), 32'd1);
    check_eq("err_sticky", 32'(overflow_err), 32'd1);
    ld_valid = 1'b0; fetch_req = 1'b0;

    // ---- reset mid-load
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst2_overflow", 32'(overflow_err), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    push_word(16'h5001, 1'b0, 0, "mid0");
    push_word(16'h5002, 1'b0, 1, "mid1");
    rst = 1'b1; ld_valid = 1'b1; ld_data = 16'h5003; #1;
    check_eq("mid_rst_no_we", 32'(mem_we), 32'd0);
    tick(); rst = 1'b0; ld_valid = 1'b0;
    check_eq("mid_rst_word_count", 32'(word_count), 32'd0);
    check_eq("mid_rst_load_done", 32'(load_done), 32'd0);
    check_eq("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    push_word(16'h6001, 1'b1, 0, "one");
    check_eq("one_word_count", 32'(word_count), 32'd1);
    check_eq("one_load_done", 32'(load_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
